// File: rtl/reg_file_sb.sv
// reg_file_sb
//   Multi-port architectural register file with an integrated busy-bit
//   scoreboard. Issue reserves destination registers; writeback writes
//   them and clears the busy bit. x0 reads zero and is never busy.
//
// Ports
//   clk_i         clock, all state updates on the rising edge
//   rst_i         synchronous active-high reset
//   rd_reg_i      packed read indices, port i at [i*ADDR_W +: ADDR_W]
//   rd_data_o     packed read data (combinational)
//   rd_busy_o     busy flag of the register addressed by each read port
//   wr_en_i       per write port enable
//   wr_reg_i      packed write indices
//   wr_data_i     packed write data
//   rsv_en_i      reservation request
//   rsv_reg_i     register to reserve
//   busy_count_o  number of currently busy registers (registered)

module reg_file_sb #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_reg_i,
    output logic [NUM_RD*XLEN-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_reg_i,
    input  logic [NUM_WR*XLEN-1:0]   wr_data_i,
    input  logic                     rsv_en_i,
    input  logic [ADDR_W-1:0]        rsv_reg_i,
    output logic [ADDR_W:0]          busy_count_o
);

    localparam logic [ADDR_W:0] CNT_ONE = 1;

    logic [XLEN-1:0]     mem_q [NUM_REGS];
    logic [XLEN-1:0]     mem_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [ADDR_W:0]     busy_count_q;
    logic [ADDR_W:0]     busy_count_d;

    logic [ADDR_W-1:0]   wr_idx [NUM_WR];
    logic [XLEN-1:0]     wr_dat [NUM_WR];
    logic [NUM_WR-1:0]   wr_act;
    logic                rsv_act;
    logic [ADDR_W-1:0]   rd_idx [NUM_RD];
    logic [NUM_RD-1:0]   fwd_hit;
    logic [ADDR_W:0]     n_set;
    logic [ADDR_W:0]     n_clr;

    // Writes and reservations aimed at x0 are dropped right here, so x0
    // never leaves its reset value of zero / not busy.
    always_comb begin
        for (int w = 0; w < NUM_WR; w++) begin
            wr_idx[w] = wr_reg_i[w*ADDR_W +: ADDR_W];
            wr_dat[w] = wr_data_i[w*XLEN +: XLEN];
            wr_act[w] = wr_en_i[w] && (wr_reg_i[w*ADDR_W +: ADDR_W] != '0);
        end
        rsv_act = rsv_en_i && (rsv_reg_i != '0);
        for (int i = 0; i < NUM_RD; i++) begin
            rd_idx[i] = rd_reg_i[i*ADDR_W +: ADDR_W];
        end
    end

    // Ascending port order makes the highest-numbered port win on a
    // shared target. The reservation is applied last so a new producer
    // outranks a same-cycle writeback of the old one.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_act[w]) begin
                mem_d[wr_idx[w]]  = wr_dat[w];
                busy_d[wr_idx[w]] = 1'b0;
            end
        end
        if (rsv_act) begin
            busy_d[rsv_reg_i] = 1'b1;
        end
    end

    // Count maintained by transition deltas rather than a full popcount
    // of busy_d; WAW reservations and writes to idle registers produce
    // no transition and leave the count alone.
    always_comb begin
        n_set = '0;
        n_clr = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (busy_d[r] && !busy_q[r]) begin
                n_set = n_set + CNT_ONE;
            end
            if (!busy_d[r] && busy_q[r]) begin
                n_clr = n_clr + CNT_ONE;
            end
        end
        busy_count_d = busy_count_q + n_set - n_clr;
    end

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        fwd_hit   = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data_o[i*XLEN +: XLEN] = mem_q[rd_idx[i]];
            if (BYPASS != 0) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_act[w] && (wr_idx[w] == rd_idx[i])) begin
                        rd_data_o[i*XLEN +: XLEN] = wr_dat[w];
                        fwd_hit[i]                = 1'b1;
                    end
                end
            end
            // A forwarded read is no longer waiting on its producer,
            // unless a new producer is being reserved in the same cycle.
            rd_busy_o[i] = busy_q[rd_idx[i]]
                           & ~(fwd_hit[i] & ~(rsv_act && (rsv_reg_i == rd_idx[i])));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem_q[r] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            mem_q        <= mem_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busy_count_o = busy_count_q;

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

    localparam int XL = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [2*AW-1:0] rd_reg;
    logic [1:0]      wr_en;
    logic [2*AW-1:0] wr_reg;
    logic [2*XL-1:0] wr_data;
    logic            rsv_en;
    logic [AW-1:0]   rsv_reg;

    logic [2*XL-1:0] rdd_b, rdd_n;
    logic [1:0]      rdb_b, rdb_n;
    logic [AW:0]     cnt_b, cnt_n;

    reg_file_sb #(.XLEN(XL), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) u_byp (
        .clk_i(clk), .rst_i(rst), .rd_reg_i(rd_reg), .rd_data_o(rdd_b), .rd_busy_o(rdb_b),
        .wr_en_i(wr_en), .wr_reg_i(wr_reg), .wr_data_i(wr_data),
        .rsv_en_i(rsv_en), .rsv_reg_i(rsv_reg), .busy_count_o(cnt_b)
    );

    reg_file_sb #(.XLEN(XL), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) u_nob (
        .clk_i(clk), .rst_i(rst), .rd_reg_i(rd_reg), .rd_data_o(rdd_n), .rd_busy_o(rdb_n),
        .wr_en_i(wr_en), .wr_reg_i(wr_reg), .wr_data_i(wr_data),
        .rsv_en_i(rsv_en), .rsv_reg_i(rsv_reg), .busy_count_o(cnt_n)
    );

    // kind: 0 = rd_data, 1 = rd_busy, 2 = busy_count; dut: 0 = bypass, 1 = no bypass
    typedef struct {
        string       name;
        int          kind;
        int          dut;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    event chk_ev;

    initial begin
        forever begin
            @(chk_ev);
            while (sb_q.size() > 0) begin
                exp_t        e;
                logic [31:0] act;
                e = sb_q.pop_front();
                case (e.kind)
                    0:       act = (e.dut != 0) ? rdd_n[e.port*XL +: XL] : rdd_b[e.port*XL +: XL];
                    1:       act = {31'b0, ((e.dut != 0) ? rdb_n[e.port] : rdb_b[e.port])};
                    default: act = {26'b0, ((e.dut != 0) ? cnt_n : cnt_b)};
                endcase
                n_checks++;
                if (act === e.exp) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s (dut=%0d port=%0d) got %h expected %h",
                             e.name, e.dut, e.port, act, e.exp);
                end
            end
        end
    end

    task automatic idle();
        rst     = 1'b0;
        rd_reg  = '0;
        wr_en   = '0;
        wr_reg  = '0;
        wr_data = '0;
        rsv_en  = 1'b0;
        rsv_reg = '0;
    endtask

    task automatic rd(input int p, input int r);
        rd_reg[p*AW +: AW] = AW'(r);
    endtask

    task automatic wr(input int p, input int r, input logic [31:0] d);
        wr_en[p]             = 1'b1;
        wr_reg[p*AW +: AW]   = AW'(r);
        wr_data[p*XL +: XL]  = d;
    endtask

    task automatic rsv(input int r);
        rsv_en  = 1'b1;
        rsv_reg = AW'(r);
    endtask

    task automatic push(input string n, input int kind, input int dut, input int port,
                        input logic [31:0] v);
        exp_t e;
        e.name = n; e.kind = kind; e.dut = dut; e.port = port; e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic ex_data(input string n, input int port, input logic [31:0] vb,
                           input logic [31:0] vn);
        push(n, 0, 0, port, vb);
        push(n, 0, 1, port, vn);
    endtask

    task automatic ex_busy(input string n, input int port, input logic vb, input logic vn);
        push(n, 1, 0, port, {31'b0, vb});
        push(n, 1, 1, port, {31'b0, vn});
    endtask

    task automatic ex_cnt(input string n, input int v);
        push(n, 2, 0, 0, 32'(v));
        push(n, 2, 1, 0, 32'(v));
    endtask

    // Let combinational outputs settle, then hand the queued expectations
    // to the monitor.
    task automatic sample();
        #2;
        ->chk_ev;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();

        // reset state
        rd(0, 5); rd(1, 6);
        ex_data("rst_data", 0, 0, 0);
        ex_busy("rst_busy", 1, 0, 0);
        ex_cnt("rst_cnt", 0);
        sample();

        // reset flush
        step();
        wr(0, 5, 32'hDEADBEEF); rsv(6);
        step();
        rd(0, 5); rd(1, 6);
        ex_data("x5_written", 0, 32'hDEADBEEF, 32'hDEADBEEF);
        ex_busy("x6_reserved", 1, 1, 1);
        ex_cnt("cnt_after_rsv6", 1);
        sample();
        step();
        rst = 1'b1; wr(0, 5, 32'h12345678); rsv(7);
        step();
        rd(0, 5); rd(1, 6);
        ex_data("flush_x5", 0, 0, 0);
        ex_busy("flush_x6", 1, 0, 0);
        ex_cnt("flush_cnt", 0);
        sample();
        step();
        rd(0, 7);
        ex_busy("flush_x7_rsv_ignored", 0, 0, 0);
        sample();

        // x0 immunity
        step();
        wr(0, 0, 32'hFFFFFFFF); rsv(0); rd(0, 0); rd(1, 0);
        ex_data("x0_same_cycle", 0, 0, 0);
        ex_busy("x0_busy_same", 1, 0, 0);
        sample();
        step();
        rd(0, 0);
        ex_data("x0_after", 0, 0, 0);
        ex_busy("x0_busy_after", 0, 0, 0);
        ex_cnt("x0_cnt", 0);
        sample();

        // write priority and bypass
        step();
        wr(0, 7, 32'h11111111); wr(1, 7, 32'h22222222); rd(0, 7); rd(1, 7);
        ex_data("prio_fwd_p0", 0, 32'h22222222, 0);
        ex_data("prio_fwd_p1", 1, 32'h22222222, 0);
        sample();
        step();
        rd(0, 7);
        ex_data("prio_stored", 0, 32'h22222222, 32'h22222222);
        sample();

        // same-cycle vs next-cycle read of a fresh write
        step();
        wr(0, 3, 32'hA5A5A5A5); rd(1, 3);
        ex_data("x3_same_cycle", 1, 32'hA5A5A5A5, 0);
        sample();
        step();
        rd(1, 3);
        ex_data("x3_next_cycle", 1, 32'hA5A5A5A5, 32'hA5A5A5A5);
        sample();

        // scoreboard sequence
        step();
        rsv(1);
        step();
        rsv(2);
        ex_cnt("rsv_cnt1", 1);
        sample();
        step();
        rsv(3);
        ex_cnt("rsv_cnt2", 2);
        sample();
        step();
        rsv(1); rd(0, 1);
        ex_cnt("rsv_cnt3", 3);
        ex_busy("x1_busy", 0, 1, 1);
        sample();
        step();
        rd(0, 1); wr(1, 2, 32'hCAFEF00D); rd(1, 2);
        ex_cnt("waw_cnt", 3);
        ex_busy("x1_still_busy", 0, 1, 1);
        ex_busy("x2_busy_wcycle", 1, 0, 1);
        ex_data("x2_data_wcycle", 1, 32'hCAFEF00D, 0);
        sample();
        step();
        rd(1, 2);
        ex_cnt("wr_clear_cnt", 2);
        ex_busy("x2_cleared", 1, 0, 0);
        ex_data("x2_stored", 1, 32'hCAFEF00D, 32'hCAFEF00D);
        sample();

        // reserve/write collision
        step();
        rsv(4);
        step();
        rd(0, 4);
        ex_cnt("rsv4_cnt", 3);
        ex_busy("x4_busy", 0, 1, 1);
        sample();
        step();
        rsv(4); wr(0, 4, 32'h44444444); rd(0, 4);
        ex_busy("coll_busy", 0, 1, 1);
        ex_data("coll_data", 0, 32'h44444444, 0);
        sample();
        step();
        rd(0, 4);
        ex_cnt("coll_cnt", 3);
        ex_busy("coll_after_busy", 0, 1, 1);
        ex_data("coll_stored", 0, 32'h44444444, 32'h44444444);
        sample();

        // two writebacks to different busy registers in one cycle
        step();
        wr(0, 1, 32'h10101010); wr(1, 3, 32'h33333333);
        step();
        rd(0, 3); rd(1, 1);
        ex_cnt("dual_clear_cnt", 1);
        ex_data("x3_overwritten", 0, 32'h33333333, 32'h33333333);
        ex_busy("x1_cleared", 1, 0, 0);
        sample();

        step();
        #5;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
